alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high.
REQ-003 SHALL have: start  in  1  begin execution (sampled in IDLE/HALT only).
REQ-004 SHALL have: imem_addr  out  8  instruction address; imem_data  in  32  synchronous ROM word, valid the cycle after imem_addr.
REQ-005 SHALL have: alu_opcode  out  5; alu_operando_a  out  32; alu_operando_b  out  32; alu_resultado  in  32; alu_C, alu_S, alu_O, alu_Z  in  1 each (combinational ALU).
REQ-006 SHALL have: st_valid  out  1; st_ready  in  1; st_addr  out  8; st_data  out  32  store port.
REQ-007 SHALL have: C, S, O, Z  out  1 registered flags; busy  out  1; done  out  1; err  out  1 sticky illegal-opcode.

Function
REQ-008 Instruction word SHALL be [31:27] op, [26:24] rd, [23:21] ra, [20:18] rb, [15:0] imm.
REQ-009 Opcodes SHALL be NOP=0, LD=1, ADD=2, MUL=3, JZ=4, JMP=5, STR=6, HLT=31; others illegal.
REQ-010 SHALL hold 8 x 32-bit registers r0..r7, all writable, and an 8-bit pc.
REQ-011 States SHALL be IDLE, FETCH, DECODE, EXEC, WB, STORE, HALT.
REQ-012 IDLE: busy=0; start=1 -> FETCH with pc=0.
REQ-013 FETCH: imem_addr=pc; -> DECODE next cycle.
REQ-014 DECODE: ir <= imem_data, operands read from ra/rb; -> EXEC, except NOP/illegal -> pc+1, FETCH; HLT -> HALT.
REQ-015 EXEC for LD: alu_opcode=LD, a=0, b=zero-extended imm; ADD/MUL: a=reg[ra], b=reg[rb]; result and four ALU flags captured at end of EXEC; -> WB.
REQ-016 WB: reg[rd] <= captured result, pc <= pc+1; -> FETCH.
REQ-017 Flags C/S/O/Z SHALL update only on LD, ADD, MUL; held otherwise.
REQ-018 EXEC for JZ: pc <= imm[7:0] if Z=1 else pc+1; JMP: pc <= imm[7:0]; -> FETCH; ALU not used (alu_opcode=NOP).
REQ-019 STR: from DECODE -> STORE; st_valid=1, st_addr=imm[7:0], st_data=reg[ra], stable while st_ready=0; transfer on st_valid&st_ready; then pc+1, -> FETCH.
REQ-020 Outside EXEC alu_opcode SHALL be NOP and both operands 0.
REQ-021 pc SHALL wrap 255 -> 0 on increment.
REQ-022 Illegal opcode SHALL set err, executed as NOP; err cleared only by reset or accepted start.
REQ-023 HALT: done=1, busy=0; start=1 -> FETCH with pc=0, flags cleared, registers retained, done cleared.
REQ-024 busy SHALL be 1 in FETCH, DECODE, EXEC, WB, STORE; start ignored while busy.
REQ-025 Latency: ALU op 4 cycles, JZ/JMP 3, NOP 2, STR 3 + st_ready wait cycles.

Reset
REQ-026 Reset SHALL force IDLE, pc=0, r0..r7=0, ir=0, flags=0, err=0, done=0, busy=0, st_valid=0, alu_opcode=NOP, operands=0, imem_addr=0 at next edge.
REQ-027 Reset SHALL take priority over start and any in-flight transfer; a STORE aborted by reset produces no transfer.

Structure
REQ-028 Opcode values and field positions SHALL be macros in the shared opcode defines header used by the ALU and benches.
REQ-029 Register file SHALL be sub-module reg_file (2 async read, 1 sync write, sync reset).
REQ-030 FSM, pc, ir, flags SHALL reside in alu_sequencer; ALU instantiated outside.

Verification (bench instantiates team ALU and ROM model)
REQ-031 LD r1,5; LD r2,7; ADD r3,r1,r2; STR r3->0x10; HLT -> one store st_addr=0x10 st_data=12, then done=1.
REQ-032 LD r1,6; LD r2,4; MUL r3,r1,r2; STR r3->0x11 -> st_data=0x18; ADD r0x80000002+0x80000001 via regs -> result 0x00000003, C=1, O=1.
REQ-033 LD r1,0 (Z=1); JZ 0x08 -> next imem_addr=0x08; LD r1,1 (Z=0); JZ 0x08 -> pc+1.
REQ-034 STR with st_ready low 3 cycles -> st_valid held 4 cycles, st_addr/st_data stable, exactly one transfer.
REQ-035 Reset asserted in STORE -> st_valid=0 next edge, IDLE, all registers 0; opcode 0x1A -> err=1, pc advances by 1.
REQ-036 JMP 0xFF then NOP at 0xFF -> next fetch at 0x00.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared opcode encodings, instruction word layout, FSM states and flag bundle
// for the ALU sequencer and its benches.
package alu_sequencer_pkg;

  localparam logic [4:0] OP_NOP = 5'd0;
  localparam logic [4:0] OP_LD  = 5'd1;
  localparam logic [4:0] OP_ADD = 5'd2;
  localparam logic [4:0] OP_MUL = 5'd3;
  localparam logic [4:0] OP_JZ  = 5'd4;
  localparam logic [4:0] OP_JMP = 5'd5;
  localparam logic [4:0] OP_STR = 6'd6;
  localparam logic [4:0] OP_HLT = 5'd31;

  // Field order fixes the bit positions: op[31:27] rd[26:24] ra[23:21] rb[20:18] imm[15:0].
  typedef struct packed {
    logic [4:0]  op;
    logic [2:0]  rd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [1:0]  rsvd;
    logic [15:0] imm;
  } instr_t;

  typedef struct packed {
    logic c;
    logic s;
    logic o;
    logic z;
  } flags_t;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_STORE, S_HALT
  } state_e;

  function automatic logic is_alu_op(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_ADD) || (op == OP_MUL);
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    return is_alu_op(op) || (op == OP_NOP) || (op == OP_JZ) || (op == OP_JMP) ||
           (op == OP_STR) || (op == OP_HLT);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction ROM, external ALU and store port bundle between the sequencer
// (master) and its surrounding memory/ALU/store sink (slave).
interface alu_sequencer_if;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_operando_a;
  logic [31:0] alu_operando_b;
  logic [31:0] alu_resultado;
  logic        alu_C;
  logic        alu_S;
  logic        alu_O;
  logic        alu_Z;
  logic        st_valid;
  logic        st_ready;
  logic [7:0]  st_addr;
  logic [31:0] st_data;

  modport master (
    output imem_addr, alu_opcode, alu_operando_a, alu_operando_b, st_valid, st_addr, st_data,
    input  imem_data, alu_resultado, alu_C, alu_S, alu_O, alu_Z, st_ready
  );

  modport slave (
    input  imem_addr, alu_opcode, alu_operando_a, alu_operando_b, st_valid, st_addr, st_data,
    output imem_data, alu_resultado, alu_C, alu_S, alu_O, alu_Z, st_ready
  );
endinterface

// File: rtl/alu_sequencer_reg_file.sv
// Eight 32-bit general registers: two asynchronous read ports, one synchronous
// write port, synchronous active-high clear.
module reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [2:0]  raddr_a,
  output logic [31:0] rdata_a,
  input  logic [2:0]  raddr_b,
  output logic [31:0] rdata_b
);

  logic [31:0] regs [8];

  // NOTE: the array is cleared on reset because software relies on r0..r7
  // reading zero; that keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '{default: '0};
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer: fetches from a synchronous ROM, drives an
// external combinational ALU, writes back to reg_file and issues stores.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  alu_sequencer_if.master       bus,
  output logic                  C,
  output logic                  S,
  output logic                  O,
  output logic                  Z,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  state_e      state_q, state_d;
  logic [7:0]  pc_q;
  instr_t      ir_q;
  instr_t      fetched;
  logic [31:0] res_q;
  flags_t      flags_q;
  logic        err_q;
  logic [31:0] rd_a, rd_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic        unused_rsvd;

  assign fetched     = instr_t'(bus.imem_data);
  assign unused_rsvd = ^ir_q.rsvd;

  reg_file u_reg_file (
    .clk     (clk),
    .reset   (reset),
    .we      (state_q == S_WB),
    .waddr   (ir_q.rd),
    .wdata   (res_q),
    .raddr_a (ir_q.ra),
    .rdata_a (rd_a),
    .raddr_b (ir_q.rb),
    .rdata_b (rd_b)
  );

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    alu_op  = OP_NOP;
    alu_a   = '0;
    alu_b   = '0;
    case (state_q)
      S_IDLE, S_HALT: if (start) state_d = S_FETCH;
      S_FETCH:        state_d = S_DECODE;
      S_DECODE: begin
        case (fetched.op)
          OP_LD, OP_ADD, OP_MUL, OP_JZ, OP_JMP: state_d = S_EXEC;
          OP_STR:  state_d = S_STORE;
          OP_HLT:  state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_EXEC: begin
        state_d = is_alu_op(ir_q.op) ? S_WB : S_FETCH;
        case (ir_q.op)
          OP_LD: begin
            alu_op = OP_LD;
            alu_b  = {16'h0000, ir_q.imm};
          end
          OP_ADD, OP_MUL: begin
            alu_op = ir_q.op;
            alu_a  = rd_a;
            alu_b  = rd_b;
          end
          default: ;
        endcase
      end
      S_WB:    state_d = S_FETCH;
      S_STORE: if (bus.st_ready) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments throughout, so every register here samples
  // the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc_q    <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
          end
        end
        S_DECODE: begin
          ir_q <= fetched;
          if (!is_legal(fetched.op)) err_q <= 1'b1;
          // Illegal opcodes retire exactly like NOP.
          if (fetched.op == OP_NOP || !is_legal(fetched.op)) pc_q <= pc_q + 8'd1;
        end
        S_EXEC: begin
          case (ir_q.op)
            OP_LD, OP_ADD, OP_MUL: begin
              res_q   <= bus.alu_resultado;
              flags_q <= '{c: bus.alu_C, s: bus.alu_S, o: bus.alu_O, z: bus.alu_Z};
            end
            OP_JZ:   pc_q <= flags_q.z ? ir_q.imm[7:0] : pc_q + 8'd1;
            OP_JMP:  pc_q <= ir_q.imm[7:0];
            default: ;
          endcase
        end
        S_WB:    pc_q <= pc_q + 8'd1;
        S_STORE: if (bus.st_ready) pc_q <= pc_q + 8'd1;
        default: ;
      endcase
    end
  end

  assign bus.imem_addr      = pc_q;
  assign bus.alu_opcode     = alu_op;
  assign bus.alu_operando_a = alu_a;
  assign bus.alu_operando_b = alu_b;
  assign bus.st_valid       = (state_q == S_STORE);
  assign bus.st_addr        = ir_q.imm[7:0];
  assign bus.st_data        = rd_a;

  assign {C, S, O, Z} = flags_q;
  assign busy = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC) ||
                (state_q == S_WB) || (state_q == S_STORE);
  assign done = (state_q == S_HALT);
  assign err  = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU, a synchronous ROM
// and a store-port monitor; expected values are hand-computed per program.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic C, S, O, Z, busy, done, err;
  int   total = 0;
  int   bad   = 0;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bus   (bus),
    .C     (C),
    .S     (S),
    .O     (O),
    .Z     (Z),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data appears the cycle after the address.
  logic [31:0] rom [256];
  always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

  // Team ALU model: LD/ADD add a+b, MUL keeps the low word.
  logic [32:0] alu_sum;
  logic [63:0] alu_prod;
  assign alu_sum  = {1'b0, bus.alu_operando_a} + {1'b0, bus.alu_operando_b};
  assign alu_prod = {32'h0, bus.alu_operando_a} * {32'h0, bus.alu_operando_b};

  always_comb begin
    bus.alu_resultado = '0;
    bus.alu_C         = 1'b0;
    bus.alu_O         = 1'b0;
    case (bus.alu_opcode)
      OP_LD, OP_ADD: begin
        bus.alu_resultado = alu_sum[31:0];
        bus.alu_C         = alu_sum[32];
        bus.alu_O         = (bus.alu_operando_a[31] == bus.alu_operando_b[31]) &&
                            (alu_sum[31] != bus.alu_operando_a[31]);
      end
      OP_MUL: begin
        bus.alu_resultado = alu_prod[31:0];
        bus.alu_C         = |alu_prod[63:32];
        bus.alu_O         = |alu_prod[63:32];
      end
      default: ;
    endcase
    bus.alu_S = bus.alu_resultado[31];
    bus.alu_Z = (bus.alu_resultado == 32'h0);
  end

  // Monitors, sampled on the falling edge.
  int          busy_cycles, valid_cycles, unstable, last_addr;
  int          trace [$];
  logic [7:0]  st_addr_q [$];
  logic [31:0] st_data_q [$];
  logic        prev_valid = 1'b0;
  logic [7:0]  prev_addr;
  logic [31:0] prev_data;

  always @(negedge clk) begin
    if (!reset) begin
      if (busy) begin
        busy_cycles++;
        if (int'(bus.imem_addr) != last_addr) begin
          trace.push_back(int'(bus.imem_addr));
          last_addr = int'(bus.imem_addr);
        end
      end
      if (bus.st_valid) begin
        valid_cycles++;
        if (prev_valid && (bus.st_addr != prev_addr || bus.st_data != prev_data)) unstable++;
      end
      if (bus.st_valid && bus.st_ready) begin
        st_addr_q.push_back(bus.st_addr);
        st_data_q.push_back(bus.st_data);
      end
    end
    prev_valid = bus.st_valid && !reset;
    prev_addr  = bus.st_addr;
    prev_data  = bus.st_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [2:0] rd,
                                      input logic [2:0] ra, input logic [2:0] rb,
                                      input logic [15:0] imm);
    return {op, rd, ra, rb, 2'b00, imm};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = {OP_HLT, 27'd0};
  endtask

  task automatic clear_logs();
    busy_cycles  = 0;
    valid_cycles = 0;
    unstable     = 0;
    last_addr    = -1;
    trace.delete();
    st_addr_q.delete();
    st_data_q.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n = 0;
    while (!done && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, done, 1'b1);
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    int n = 0;
    while (!bus.st_valid && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid_seen"}, bus.st_valid, 1'b1);
  endtask

  task automatic check_trace(input string tag, input int exp_t [$]);
    check({tag, "_len"}, trace.size(), exp_t.size());
    for (int i = 0; i < exp_t.size(); i++)
      if (i < trace.size()) check($sformatf("%s_%0d", tag, i), trace[i], exp_t[i]);
  endtask

  task automatic check_store(input string tag, input int idx, input logic [7:0] addr,
                             input logic [31:0] data);
    if (idx < st_addr_q.size()) begin
      check({tag, "_addr"}, st_addr_q[idx], addr);
      check({tag, "_data"}, st_data_q[idx], data);
    end
  endtask

  initial begin
    int exp_t [$];
    reset       = 1'b1;
    start       = 1'b0;
    bus.st_ready = 1'b1;
    clear_rom();
    clear_logs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_st_valid", bus.st_valid, 1'b0);
    check("rst_imem_addr", bus.imem_addr, 8'h00);
    check("rst_alu_opcode", bus.alu_opcode, OP_NOP);
    check("rst_alu_a", bus.alu_operando_a, 32'h0);
    check("rst_alu_b", bus.alu_operando_b, 32'h0);
    check("rst_flags", {C, S, O, Z}, 4'b0000);

    // 5 + 7 stored at 0x10: LD/LD/ADD 4 cycles each, STR 3, HLT 2.
    clear_rom();
    rom[0] = enc(OP_LD, 3'd1, 3'd0, 3'd0, 16'd5);
    rom[1] = enc(OP_LD, 3'd2, 3'd0, 3'd0, 16'd7);
    rom[2] = enc(OP_ADD, 3'd3, 3'd1, 3'd2, 16'd0);
    rom[3] = enc(OP_STR, 3'd0, 3'd3, 3'd0, 16'h0010);
    clear_logs();
    pulse_start();
    wait_done("add", 200);
    check("add_nstores", st_addr_q.size(), 1);
    check_store("add_st0", 0, 8'h10, 32'd12);
    check("add_busy_cycles", busy_cycles, 17);
    check("add_busy_in_halt", busy, 1'b0);
    check("add_flags", {C, S, O, Z}, 4'b0000);

    // MUL 6*4, then 0x80000002 + 0x80000001 built from 16-bit loads.
    clear_rom();
    rom[0]  = enc(OP_LD,  3'd1, 3'd0, 3'd0, 16'd6);
    rom[1]  = enc(OP_LD,  3'd2, 3'd0, 3'd0, 16'd4);
    rom[2]  = enc(OP_MUL, 3'd3, 3'd1, 3'd2, 16'd0);
    rom[3]  = enc(OP_STR, 3'd0, 3'd3, 3'd0, 16'h0011);
    rom[4]  = enc(OP_LD,  3'd1, 3'd0, 3'd0, 16'h8000);
    rom[5]  = enc(OP_MUL, 3'd2, 3'd1, 3'd1, 16'd0);
    rom[6]  = enc(OP_ADD, 3'd2, 3'd2, 3'd2, 16'd0);
    rom[7]  = enc(OP_LD,  3'd3, 3'd0, 3'd0, 16'd2);
    rom[8]  = enc(OP_ADD, 3'd4, 3'd2, 3'd3, 16'd0);
    rom[9]  = enc(OP_LD,  3'd3, 3'd0, 3'd0, 16'd1);
    rom[10] = enc(OP_ADD, 3'd5, 3'd2, 3'd3, 16'd0);
    rom[11] = enc(OP_ADD, 3'd6, 3'd4, 3'd5, 16'd0);
    rom[12] = enc(OP_STR, 3'd0, 3'd6, 3'd0, 16'h0012);
    clear_logs();
    pulse_start();
    wait_done("mul", 400);
    check("mul_nstores", st_addr_q.size(), 2);
    check_store("mul_st0", 0, 8'h11, 32'h0000_0018);
    check_store("mul_st1", 1, 8'h12, 32'h0000_0003);
    check("ovf_flags_CSOZ", {C, S, O, Z}, 4'b1010);

    // JZ taken after LD 0, not taken after LD 1.
    clear_rom();
    rom[0]  = enc(OP_LD,  3'd1, 3'd0, 3'd0, 16'd0);
    rom[1]  = enc(OP_JZ,  3'd0, 3'd0, 3'd0, 16'h0008);
    rom[8]  = enc(OP_LD,  3'd1, 3'd0, 3'd0, 16'd1);
    rom[9]  = enc(OP_JZ,  3'd0, 3'd0, 3'd0, 16'h0020);
    rom[10] = enc(OP_STR, 3'd0, 3'd1, 3'd0, 16'h0033);
    clear_logs();
    pulse_start();
    wait_done("jz", 200);
    exp_t = {0, 1, 8, 9, 10, 11};
    check_trace("jz_trace", exp_t);
    check("jz_nstores", st_addr_q.size(), 1);
    check_store("jz_st0", 0, 8'h33, 32'd1);
    check("jz_flags", {C, S, O, Z}, 4'b0000);

    // JMP to 0xFF, NOP there wraps pc to 0, where JZ now sees Z=1.
    clear_rom();
    rom[0]   = enc(OP_JZ,  3'd0, 3'd0, 3'd0, 16'h0005);
    rom[1]   = enc(OP_LD,  3'd7, 3'd0, 3'd0, 16'd0);
    rom[2]   = enc(OP_JMP, 3'd0, 3'd0, 3'd0, 16'h00FF);
    rom[255] = enc(OP_NOP, 3'd0, 3'd0, 3'd0, 16'd0);
    clear_logs();
    pulse_start();
    wait_done("wrap", 200);
    exp_t = {0, 1, 2, 255, 0, 5};
    check_trace("wrap_trace", exp_t);
    check("wrap_flags", {C, S, O, Z}, 4'b0001);

    // Store held off by st_ready low for three cycles.
    bus.st_ready = 1'b0;
    clear_rom();
    rom[0] = enc(OP_LD,  3'd2, 3'd0, 3'd0, 16'h1234);
    rom[1] = enc(OP_STR, 3'd0, 3'd2, 3'd0, 16'h0040);
    clear_logs();
    pulse_start();
    wait_valid("stall", 50);
    repeat (3) @(posedge clk);
    #1 bus.st_ready = 1'b1;
    wait_done("stall", 100);
    check("stall_valid_cycles", valid_cycles, 4);
    check("stall_unstable", unstable, 0);
    check("stall_nstores", st_addr_q.size(), 1);
    check_store("stall_st0", 0, 8'h40, 32'h0000_1234);

    // Reset in the middle of a stalled store.
    bus.st_ready = 1'b0;
    clear_rom();
    rom[0] = enc(OP_LD,  3'd2, 3'd0, 3'd0, 16'd9);
    rom[1] = enc(OP_LD,  3'd1, 3'd0, 3'd0, 16'd0);
    rom[2] = enc(OP_STR, 3'd0, 3'd2, 3'd0, 16'h0050);
    clear_logs();
    pulse_start();
    wait_valid("rststore", 50);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rststore_st_valid", bus.st_valid, 1'b0);
    check("rststore_busy", busy, 1'b0);
    check("rststore_imem_addr", bus.imem_addr, 8'h00);
    check("rststore_flags", {C, S, O, Z}, 4'b0000);
    check("rststore_nstores", st_addr_q.size(), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    bus.st_ready = 1'b1;
    clear_rom();
    rom[0] = enc(OP_STR, 3'd0, 3'd2, 3'd0, 16'h0051);
    clear_logs();
    pulse_start();
    wait_done("postrst", 100);
    check("postrst_nstores", st_addr_q.size(), 1);
    check_store("postrst_st0", 0, 8'h51, 32'h0);

    // Illegal opcode 0x1A: flagged, retired as NOP, cleared by the next start.
    clear_rom();
    rom[0] = {5'h1A, 27'd0};
    clear_logs();
    pulse_start();
    wait_done("illegal", 100);
    check("illegal_err", err, 1'b1);
    exp_t = {0, 1};
    check_trace("illegal_trace", exp_t);
    check("illegal_busy_cycles", busy_cycles, 4);
    clear_logs();
    pulse_start();
    @(negedge clk);
    check("illegal_err_cleared", err, 1'b0);
    wait_done("illegal2", 100);
    check("illegal_err_again", err, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
